alarm_controller: RTL and testbench

Sequences the alarm function of the clock. It compares running time against the alarm setting produced by the time/alarm adjust block and runs the arm/ring/snooze/stop state machine. It drives the buzzer beep pattern and the status outputs. It sits between the timekeeping counters, the adjust block and the buzzer/LED drivers.

---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_match_detect.sv | 27 ++
 rtl/alarm_controller.sv | 128 ++++++++++++
 tb/tb_alarm_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared encodings, field widths and defaults for the alarm controller slice.
package alarm_pkg;

  localparam int HOUR_W     = 5;
  localparam int MIN_W      = 6;
  localparam int SNOOZE_W   = 10;
  localparam int COUNT_W    = 3;
  localparam int RING_CNT_W = 8;

  localparam int DEF_SNOOZE_MIN     = 5;
  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_MAX_SNOOZE     = 3;

  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] RINGING  = 2'd2;
  localparam logic [1:0] SNOOZE   = 2'd3;

  // Complete registered state of the controller; all-zero is the reset value.
  typedef struct packed {
    logic [1:0]            state;
    logic                  buzzer;
    logic [SNOOZE_W-1:0]   snooze_left;
    logic [COUNT_W-1:0]    snooze_count;
    logic                  missed;
    logic [RING_CNT_W-1:0] ring_cnt;
    logic                  beep_phase;
  } alarm_regs_t;

  function automatic logic [RING_CNT_W-1:0] sat_inc(input logic [RING_CNT_W-1:0] v);
    return (v == '1) ? v : v + RING_CNT_W'(1);
  endfunction

endpackage

// File: rtl/alarm_match_detect.sv
// Compares running time with the alarm setting and flags the first clk of a match.
module alarm_match_detect
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [HOUR_W-1:0] time_hours,
  input  logic [MIN_W-1:0]  time_minutes,
  input  logic [HOUR_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]  alarm_minutes,
  output logic              match_rise
);

  logic match;
  logic match_q;

  assign match = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);

  // Tracks match in every state so a match already present never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match_q <= 1'b0;
    else        match_q <= match;
  end

  assign match_rise = match & ~match_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm arm/ring/snooze/stop sequencer with beep pattern and status outputs.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = DEF_SNOOZE_MIN,
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [HOUR_W-1:0]   time_hours,
  input  logic [MIN_W-1:0]    time_minutes,
  input  logic [HOUR_W-1:0]   alarm_hours,
  input  logic [MIN_W-1:0]    alarm_minutes,
  input  logic                alarm_en,
  input  logic                adjusting,
  input  logic                key_snooze,
  input  logic                key_stop,
  output logic                buzzer,
  output logic [1:0]          state_out,
  output logic [SNOOZE_W-1:0] snooze_left_s,
  output logic [COUNT_W-1:0]  snooze_count,
  output logic                missed
);

  localparam logic [SNOOZE_W-1:0]   SNOOZE_LOAD = SNOOZE_W'(SNOOZE_MIN * 60);
  localparam logic [RING_CNT_W-1:0] RING_LIMIT  = RING_CNT_W'(RING_TIMEOUT_S);
  localparam logic [COUNT_W-1:0]    SNOOZE_MAX  = COUNT_W'(MAX_SNOOZE);

  alarm_regs_t           q;
  alarm_regs_t           d;
  logic                  match_rise;
  logic                  tick;
  logic [RING_CNT_W-1:0] ring_next;

  alarm_match_detect u_match (
    .clk           (clk),
    .reset         (reset),
    .time_hours    (time_hours),
    .time_minutes  (time_minutes),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .match_rise    (match_rise)
  );

  // Entry into RINGING; snooze_count and missed are handled by the caller.
  function automatic alarm_regs_t start_ring(input alarm_regs_t r);
    alarm_regs_t n;
    n            = r;
    n.state      = RINGING;
    n.ring_cnt   = '0;
    n.beep_phase = 1'b1;
    n.buzzer     = 1'b1;
    return n;
  endfunction

  // A key press in the same clk swallows the second tick.
  assign tick      = sec_tick & ~(key_stop | key_snooze);
  assign ring_next = sat_inc(q.ring_cnt);

  always_comb begin
    d = q;
    if (!alarm_en) begin
      d.state        = DISARMED;
      d.buzzer       = 1'b0;
      d.snooze_left  = '0;
      d.snooze_count = '0;
      d.ring_cnt     = '0;
      d.beep_phase   = 1'b0;
    end else begin
      case (q.state)
        DISARMED: d.state = ARMED;
        ARMED: begin
          if (match_rise && !adjusting) begin
            d              = start_ring(q);
            d.snooze_count = '0;
            d.missed       = 1'b0;
          end
        end
        RINGING: begin
          if (key_stop || (key_snooze && q.snooze_count >= SNOOZE_MAX)) begin
            d.state  = ARMED;
            d.buzzer = 1'b0;
          end else if (key_snooze) begin
            d.state        = SNOOZE;
            d.snooze_left  = SNOOZE_LOAD;
            d.snooze_count = q.snooze_count + COUNT_W'(1);
            d.buzzer       = 1'b0;
          end else if (tick) begin
            d.ring_cnt = ring_next;
            if (ring_next == RING_LIMIT) begin
              d.state  = ARMED;
              d.missed = 1'b1;
              d.buzzer = 1'b0;
            end else begin
              d.beep_phase = ~q.beep_phase;
              d.buzzer     = ~q.beep_phase;
            end
          end
        end
        SNOOZE: begin
          if (key_stop) begin
            d.state       = ARMED;
            d.snooze_left = '0;
          end else if (tick && q.snooze_left != '0) begin
            d.snooze_left = q.snooze_left - SNOOZE_W'(1);
            if (q.snooze_left == SNOOZE_W'(1)) d = start_ring(d);
          end
        end
        default: d.state = DISARMED;
      endcase
    end
  end

  // All-zero reset matches DISARMED with every counter and flag cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

  assign buzzer        = q.buzzer;
  assign state_out     = q.state;
  assign snooze_left_s = q.snooze_left;
  assign snooze_count  = q.snooze_count;
  assign missed        = q.missed;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a queue-based output scoreboard.
module tb_alarm_controller;

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARM = 2'd1;
  localparam logic [1:0] S_RNG = 2'd2;
  localparam logic [1:0] S_SNZ = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en;
  logic       adjusting;
  logic       key_snooze;
  logic       key_stop;
  logic       buzzer;
  logic [1:0] state_out;
  logic [9:0] snooze_left_s;
  logic [2:0] snooze_count;
  logic       missed;

  int errors = 0;
  int checks = 0;

  // Packed expectation: {state, buzzer, snooze_left, snooze_count, missed}
  logic [16:0] exp_q[$];
  string       name_q[$];

  alarm_controller #(
    .SNOOZE_MIN     (1),
    .RING_TIMEOUT_S (5),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sec_tick      (sec_tick),
    .time_hours    (time_hours),
    .time_minutes  (time_minutes),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_en      (alarm_en),
    .adjusting     (adjusting),
    .key_snooze    (key_snooze),
    .key_stop      (key_stop),
    .buzzer        (buzzer),
    .state_out     (state_out),
    .snooze_left_s (snooze_left_s),
    .snooze_count  (snooze_count),
    .missed        (missed)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m);
    time_hours   = 5'(h);
    time_minutes = 6'(m);
    clk_step();
  endtask

  task automatic press(input logic stop, input logic snz);
    key_stop   = stop;
    key_snooze = snz;
    clk_step();
    key_stop   = 1'b0;
    key_snooze = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      clk_step();
      sec_tick = 1'b0;
      clk_step();
    end
  endtask

  task automatic ring_again();
    set_time(6, 1);
    set_time(6, 0);
  endtask

  task automatic push_exp(input string name, input logic [1:0] st, input logic bz,
                          input int sl, input int cnt, input logic ms);
    exp_q.push_back({st, bz, 10'(sl), 3'(cnt), ms});
    name_q.push_back(name);
  endtask

  // Scoreboard monitor: checks the outputs on the falling edge after each push.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin : mon
      logic [16:0] e;
      logic [16:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {state_out, buzzer, snooze_left_s, snooze_count, missed};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d buzzer=%0d snooze_left=%0d count=%0d missed=%0d, want state=%0d buzzer=%0d snooze_left=%0d count=%0d missed=%0d",
                 n, a[16:15], a[14], a[13:4], a[3:1], a[0],
                 e[16:15], e[14], e[13:4], e[3:1], e[0]);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: bench did not complete, time=%0t limit=100000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    reset         = 1'b0;
    sec_tick      = 1'b0;
    key_stop      = 1'b0;
    key_snooze    = 1'b0;
    adjusting     = 1'b0;
    alarm_en      = 1'b0;
    time_hours    = 5'd5;
    time_minutes  = 6'd59;
    alarm_hours   = 5'd6;
    alarm_minutes = 6'd0;
    repeat (2) clk_step();
    push_exp("reset_values", S_DIS, 0, 0, 0, 0);
    reset    = 1'b1;
    alarm_en = 1'b1;
    clk_step();
    push_exp("arm", S_ARM, 0, 0, 0, 0);

    // Ring on the 05:59 -> 06:00 edge, beep toggles, stop
    set_time(6, 0);
    push_exp("ring_start", S_RNG, 1, 0, 0, 0);
    tick(1);
    push_exp("beep_off", S_RNG, 0, 0, 0, 0);
    tick(1);
    push_exp("beep_on", S_RNG, 1, 0, 0, 0);
    press(1, 0);
    push_exp("stop", S_ARM, 0, 0, 0, 0);

    // Snooze twice, third press acts as stop
    set_time(6, 1);
    push_exp("armed_0601", S_ARM, 0, 0, 0, 0);
    set_time(6, 0);
    push_exp("ring2", S_RNG, 1, 0, 0, 0);
    press(0, 1);
    push_exp("snooze1", S_SNZ, 0, 60, 1, 0);
    tick(1);
    push_exp("snooze_dec", S_SNZ, 0, 59, 1, 0);
    tick(58);
    push_exp("snooze_last", S_SNZ, 0, 1, 1, 0);
    tick(1);
    push_exp("snooze_expire", S_RNG, 1, 0, 1, 0);
    press(0, 1);
    push_exp("snooze2", S_SNZ, 0, 60, 2, 0);
    tick(60);
    push_exp("ring_after2", S_RNG, 1, 0, 2, 0);
    press(0, 1);
    push_exp("snooze_limit", S_ARM, 0, 0, 2, 0);

    // Ring timeout sets missed; next event clears it
    set_time(6, 1);
    push_exp("armed_keeps_count", S_ARM, 0, 0, 2, 0);
    set_time(6, 0);
    push_exp("ring3", S_RNG, 1, 0, 0, 0);
    tick(4);
    push_exp("ring_4_ticks", S_RNG, 1, 0, 0, 0);
    tick(1);
    push_exp("timeout", S_ARM, 0, 0, 0, 1);
    ring_again();
    push_exp("missed_clear", S_RNG, 1, 0, 0, 0);
    press(1, 0);
    push_exp("stop3", S_ARM, 0, 0, 0, 0);

    // Match while adjusting, and enabling on an existing match, never ring
    set_time(6, 1);
    adjusting = 1'b1;
    set_time(6, 0);
    push_exp("adjust_hold", S_ARM, 0, 0, 0, 0);
    adjusting = 1'b0;
    clk_step();
    push_exp("adjust_release", S_ARM, 0, 0, 0, 0);
    repeat (2) clk_step();
    push_exp("adjust_quiet", S_ARM, 0, 0, 0, 0);
    alarm_en = 1'b0;
    clk_step();
    push_exp("disarm", S_DIS, 0, 0, 0, 0);
    alarm_en = 1'b1;
    clk_step();
    push_exp("enable_on_match", S_ARM, 0, 0, 0, 0);
    repeat (3) clk_step();
    push_exp("no_ring", S_ARM, 0, 0, 0, 0);

    // Stop beats snooze; disarm clears a snooze in progress
    ring_again();
    push_exp("ring5", S_RNG, 1, 0, 0, 0);
    press(1, 1);
    push_exp("stop_wins", S_ARM, 0, 0, 0, 0);
    ring_again();
    press(0, 1);
    push_exp("snooze5", S_SNZ, 0, 60, 1, 0);
    alarm_hours = 5'd7;
    tick(2);
    push_exp("snooze_keeps", S_SNZ, 0, 58, 1, 0);
    alarm_en = 1'b0;
    clk_step();
    push_exp("disarm_snooze", S_DIS, 0, 0, 0, 0);
    alarm_hours = 5'd6;
    alarm_en    = 1'b1;
    clk_step();
    push_exp("rearm", S_ARM, 0, 0, 0, 0);

    // Asynchronous reset mid-ring
    ring_again();
    tick(2);
    push_exp("ring6", S_RNG, 1, 0, 0, 0);
    clk_step();
    reset = 1'b0;
    #1;
    push_exp("async_reset", S_DIS, 0, 0, 0, 0);
    clk_step();
    alarm_en     = 1'b0;
    time_minutes = 6'd30;
    clk_step();
    reset = 1'b1;
    clk_step();
    push_exp("post_reset_idle", S_DIS, 0, 0, 0, 0);
    clk_step();
    push_exp("still_disarmed", S_DIS, 0, 0, 0, 0);
    alarm_en = 1'b1;
    clk_step();
    push_exp("arm_after_reset", S_ARM, 0, 0, 0, 0);
    clk_step();
    push_exp("quiet_after_reset", S_ARM, 0, 0, 0, 0);

    repeat (2) clk_step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
